// File: rtl/instr_fetch_if.sv
// rtl/instr_fetch_if.sv - fetch-unit bus bundle: program counter, instruction memory and decoder handshake
interface instr_fetch_if #(
  parameter int bits = 8
);
  logic [bits-1:0] pc_count;
  logic            pc_en;
  logic [2:0]      pc_imm;
  logic            mem_rd;
  logic [bits-1:0] mem_addr;
  logic [7:0]      mem_rdata;
  logic [7:0]      instr;
  logic            instr_valid;
  logic            instr_ready;

  modport master (
    input  pc_count, mem_rdata, instr_ready,
    output pc_en, pc_imm, mem_rd, mem_addr, instr, instr_valid
  );

  modport slave (
    output pc_count, mem_rdata, instr_ready,
    input  pc_en, pc_imm, mem_rd, mem_addr, instr, instr_valid
  );
endinterface

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - five-state instruction fetch FSM; JMP decode enabled by macro INSTR_FETCH_JMP_EN
module instr_fetch #(
  parameter int bits = 8
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           run,
  output logic           halted,
  instr_fetch_if.master  bus
);

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_REQ  = 3'd1;
  localparam logic [2:0] ST_WAIT = 3'd2;
  localparam logic [2:0] ST_HOLD = 3'd3;
  localparam logic [2:0] ST_STEP = 3'd4;

  localparam logic [7:0] HALT_WORD = 8'hFF;

  logic [2:0] state_q, state_d;
  logic [7:0] instr_q, instr_d;
  logic       halted_q, halted_d;

  logic       is_halt;
  logic       is_jmp;

  assign is_halt = (instr_q == HALT_WORD);

`ifdef INSTR_FETCH_JMP_EN
  assign is_jmp = (instr_q[7:3] == 5'b11100);
`else
  assign is_jmp = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    instr_d  = instr_q;
    halted_d = halted_q;
    case (state_q)
      ST_IDLE: begin
        if (run && !halted_q) begin
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        instr_d = bus.mem_rdata;
        state_d = ST_HOLD;
      end
      ST_HOLD: begin
        if (bus.instr_ready) begin
          state_d = ST_STEP;
        end
      end
      ST_STEP: begin
        // A consumed HALT word parks the FSM until the next reset.
        if (is_halt) begin
          halted_d = 1'b1;
          state_d  = ST_IDLE;
        end else if (run) begin
          state_d = ST_REQ;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      instr_q  <= 8'h00;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      instr_q  <= instr_d;
      halted_q <= halted_d;
    end
  end

  assign bus.mem_rd      = (state_q == ST_REQ);
  assign bus.mem_addr    = bus.mem_rd ? bus.pc_count : '0;
  assign bus.instr_valid = (state_q == ST_HOLD);
  assign bus.instr       = instr_q;
  assign bus.pc_en       = (state_q == ST_STEP) && !is_halt;
  assign bus.pc_imm      = !bus.pc_en ? 3'b000 : (is_jmp ? instr_q[2:0] : 3'b001);
  assign halted          = halted_q;

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - directed self-checking bench for instr_fetch
module tb_instr_fetch;

  logic clk;
  logic reset;
  logic run;
  logic halted;

  instr_fetch_if #(.bits(8)) bus ();

  instr_fetch #(.bits(8)) dut (
    .clk    (clk),
    .reset  (reset),
    .run    (run),
    .halted (halted),
    .bus    (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [7:0] mem [256];
  logic       rd_d1;
  logic [7:0] addr_d1;
  logic [7:0] next_pc;

`ifdef INSTR_FETCH_JMP_EN
  localparam logic [2:0] JMP_IMM = 3'b101;
`else
  localparam logic [2:0] JMP_IMM = 3'b001;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory answers one cycle after the read strobe; otherwise it drives a marker value.
  always @(posedge clk) begin
    rd_d1   <= bus.mem_rd;
    addr_d1 <= bus.mem_addr;
  end
  assign bus.mem_rdata = rd_d1 ? mem[addr_d1] : 8'h3C;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_instr"}, 32'(bus.instr), 32'h00);
    check({tag, "_valid"}, 32'(bus.instr_valid), 32'h0);
    check({tag, "_pc_en"}, 32'(bus.pc_en), 32'h0);
    check({tag, "_pc_imm"}, 32'(bus.pc_imm), 32'h0);
    check({tag, "_mem_rd"}, 32'(bus.mem_rd), 32'h0);
    check({tag, "_mem_addr"}, 32'(bus.mem_addr), 32'h0);
    check({tag, "_halted"}, 32'(halted), 32'h0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h00] = 8'h12;
    mem[8'h01] = 8'h34;
    mem[8'h02] = 8'hE5;
    mem[8'h03] = 8'h56;
    mem[8'h07] = 8'h56;
    mem[8'hFF] = 8'h21;
    mem[8'h40] = 8'h77;
    mem[8'h04] = 8'hFF;

    reset = 1'b1;
    run = 1'b0;
    bus.pc_count = 8'h00;
    bus.instr_ready = 1'b0;
    tick();
    tick();
    check_reset_vals("rst");

    // Basic fetch: mem_rd cycle 1, instr_valid cycle 3, pc_en cycle 4
    reset = 1'b0;
    run = 1'b1;
    bus.instr_ready = 1'b1;
    tick();
    check("c1_mem_rd", 32'(bus.mem_rd), 32'h1);
    check("c1_mem_addr", 32'(bus.mem_addr), 32'h00);
    check("c1_pc_en", 32'(bus.pc_en), 32'h0);
    tick();
    check("c2_mem_rd", 32'(bus.mem_rd), 32'h0);
    check("c2_valid", 32'(bus.instr_valid), 32'h0);
    tick();
    check("c3_valid", 32'(bus.instr_valid), 32'h1);
    check("c3_instr", 32'(bus.instr), 32'h12);
    check("c3_pc_en", 32'(bus.pc_en), 32'h0);
    tick();
    check("c4_pc_en", 32'(bus.pc_en), 32'h1);
    check("c4_pc_imm", 32'(bus.pc_imm), 32'h1);
    check("c4_mem_rd", 32'(bus.mem_rd), 32'h0);
    check("c4_valid", 32'(bus.instr_valid), 32'h0);
    bus.pc_count = 8'h01;
    bus.instr_ready = 1'b0;

    // Decoder back-pressure: five cycles held in HOLD
    tick();
    check("bp_mem_rd", 32'(bus.mem_rd), 32'h1);
    check("bp_mem_addr", 32'(bus.mem_addr), 32'h01);
    tick();
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_hold_valid", 32'(bus.instr_valid), 32'h1);
      check("bp_hold_instr", 32'(bus.instr), 32'h34);
      check("bp_hold_pc_en", 32'(bus.pc_en), 32'h0);
    end
    bus.instr_ready = 1'b1;
    tick();
    check("bp_step_pc_en", 32'(bus.pc_en), 32'h1);
    check("bp_step_pc_imm", 32'(bus.pc_imm), 32'h1);
    bus.pc_count = 8'h02;

    // JMP +5 word
    tick();
    check("jmp_mem_addr", 32'(bus.mem_addr), 32'h02);
    tick();
    tick();
    check("jmp_instr", 32'(bus.instr), 32'hE5);
    tick();
    check("jmp_pc_en", 32'(bus.pc_en), 32'h1);
    check("jmp_pc_imm", 32'(bus.pc_imm), 32'(JMP_IMM));
    next_pc = 8'h02 + 8'(JMP_IMM);
    bus.pc_count = next_pc;

    // run dropped mid-fetch: word still completes, then IDLE
    tick();
    check("stop_mem_rd", 32'(bus.mem_rd), 32'h1);
    check("stop_mem_addr", 32'(bus.mem_addr), 32'(next_pc));
    run = 1'b0;
    tick();
    tick();
    check("stop_valid", 32'(bus.instr_valid), 32'h1);
    check("stop_instr", 32'(bus.instr), 32'h56);
    tick();
    check("stop_pc_en", 32'(bus.pc_en), 32'h1);
    check("stop_pc_imm", 32'(bus.pc_imm), 32'h1);
    tick();
    check("stop_idle_mem_rd", 32'(bus.mem_rd), 32'h0);
    check("stop_idle_pc_en", 32'(bus.pc_en), 32'h0);
    tick();
    check("stop_idle2_mem_rd", 32'(bus.mem_rd), 32'h0);

    // Address wrap is the counter's business: FF then 00 fetched as-is
    bus.pc_count = 8'hFF;
    run = 1'b1;
    tick();
    check("wrap_addr_ff", 32'(bus.mem_addr), 32'hFF);
    tick();
    tick();
    check("wrap_instr", 32'(bus.instr), 32'h21);
    tick();
    check("wrap_pc_en", 32'(bus.pc_en), 32'h1);
    bus.pc_count = 8'h00;
    tick();
    check("wrap_addr_00", 32'(bus.mem_addr), 32'h00);
    check("wrap_mem_rd", 32'(bus.mem_rd), 32'h1);

    // Reset during WAIT
    tick();
    reset = 1'b1;
    tick();
    check_reset_vals("rst_wait");
    reset = 1'b0;

    // Reset during HOLD with an unaccepted word
    bus.pc_count = 8'h40;
    bus.instr_ready = 1'b0;
    tick();
    check("rh_mem_addr", 32'(bus.mem_addr), 32'h40);
    tick();
    tick();
    check("rh_valid", 32'(bus.instr_valid), 32'h1);
    check("rh_instr", 32'(bus.instr), 32'h77);
    reset = 1'b1;
    bus.instr_ready = 1'b1;
    tick();
    check_reset_vals("rst_hold");
    reset = 1'b0;
    run = 1'b0;
    tick();
    check("rh_after_pc_en", 32'(bus.pc_en), 32'h0);
    check("rh_after_mem_rd", 32'(bus.mem_rd), 32'h0);

    // HALT word: handshake, no pc_en, sticky halted
    bus.pc_count = 8'h04;
    run = 1'b1;
    tick();
    check("halt_mem_addr", 32'(bus.mem_addr), 32'h04);
    tick();
    tick();
    check("halt_valid", 32'(bus.instr_valid), 32'h1);
    check("halt_instr", 32'(bus.instr), 32'hFF);
    tick();
    check("halt_step_pc_en", 32'(bus.pc_en), 32'h0);
    check("halt_step_pc_imm", 32'(bus.pc_imm), 32'h0);
    check("halt_step_valid", 32'(bus.instr_valid), 32'h0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("halt_idle_halted", 32'(halted), 32'h1);
      check("halt_idle_mem_rd", 32'(bus.mem_rd), 32'h0);
      check("halt_idle_pc_en", 32'(bus.pc_en), 32'h0);
    end
    reset = 1'b1;
    tick();
    check("halt_cleared", 32'(halted), 32'h0);
    reset = 1'b0;
    bus.pc_count = 8'h00;
    tick();
    check("post_halt_mem_rd", 32'(bus.mem_rd), 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter bits, default 8, SHALL set the width of the program-counter value and the memory address.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 reset  input  1  SHALL be a synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 run  input  1  SHALL be the fetch enable; while high, the block issues fetches.
REQ-005 pc_count  input  bits  SHALL carry the current value of the program counter.
REQ-006 pc_en  output  1  SHALL be a one-cycle strobe telling the program counter to add pc_imm.
REQ-007 pc_imm  output  3  SHALL carry the offset applied on pc_en.
REQ-008 mem_rd  output  1  SHALL be the instruction-memory read strobe.
REQ-009 mem_addr  output  bits  SHALL carry the read address.
REQ-010 mem_rdata  input  8  SHALL carry read data, valid exactly one cycle after mem_rd.
REQ-011 instr  output  8  SHALL carry the held instruction word to the decoder.
REQ-012 instr_valid  output  1  SHALL indicate that instr is valid.
REQ-013 instr_ready  input  1  SHALL be the decoder's accept signal.
REQ-014 halted  output  1  SHALL be a sticky indication that a HALT word was consumed.

Function
REQ-015 The FSM SHALL have exactly five states: IDLE, REQ, WAIT, HOLD, STEP.
REQ-016 IDLE: all strobes low; go to REQ when run=1 and halted=0, else stay in IDLE.
REQ-017 REQ: mem_rd=1 and mem_addr=pc_count for exactly one cycle; then go to WAIT.
REQ-018 WAIT: capture mem_rdata into the instr register; then go to HOLD.
REQ-019 HOLD: instr_valid=1 and instr held stable; stay in HOLD until instr_valid&&instr_ready, then go to STEP.
REQ-020 STEP: pc_en=1 for exactly one cycle; next state is REQ if run=1 and no HALT, else IDLE.
REQ-021 pc_imm SHALL be 3'b001 in STEP for sequential words and instr[2:0] for JMP words (instr[7:3]=5'b11100); pc_imm=0 whenever pc_en=0.
REQ-022 A JMP with offset 0 SHALL refetch the same address; no special casing.
REQ-023 HALT (instr=8'hFF) SHALL complete its handshake, skip pc_en in STEP, set halted=1, and return to IDLE.
REQ-024 Minimum latency SHALL be REQ-to-instr_valid = 2 cycles; the full fetch loop SHALL take 4 cycles when instr_ready is already high.
REQ-025 run is sampled only in IDLE and STEP; deasserting it mid-fetch SHALL let the current word complete its handshake and PC step.
REQ-026 mem_addr SHALL equal pc_count without modification; wrap-around is owned by the counter (e.g. 8'hFF+1 -> 8'h00 fetched normally).
REQ-027 pc_en and mem_rd SHALL never be high in the same cycle.

Reset
REQ-028 On reset=1 at a clock edge: state=IDLE, instr=8'h00, instr_valid=0, pc_en=0, pc_imm=0, mem_rd=0, mem_addr=0, halted=0.
REQ-029 Reset in any state, including HOLD with an unaccepted word, SHALL drop the word with no pc_en.
REQ-030 Reset has priority over run and instr_ready.

Configuration
REQ-031 With macro INSTR_FETCH_JMP_EN defined, JMP decoding per REQ-021 SHALL be active.
REQ-032 Without INSTR_FETCH_JMP_EN, every non-HALT word SHALL step with pc_imm=3'b001; JMP words are passed to the decoder as ordinary words.

Verification
REQ-033 Reset, then run=1 with pc_count=8'h00 and mem word 8'h12, instr_ready=1 -> mem_rd at cycle 1, instr_valid=1 with instr=8'h12 at cycle 3, pc_en=1 with pc_imm=3'b001 at cycle 4.
REQ-034 instr_ready held low for 5 cycles in HOLD -> instr stable, instr_valid=1 throughout, no pc_en until 1 cycle after ready rises.
REQ-035 Word 8'hE5 (JMP +5) with the macro defined -> pc_imm=3'b101 in STEP; without the macro -> pc_imm=3'b001.
REQ-036 Word 8'hFF -> handshake completes, no pc_en, halted=1, FSM stays in IDLE with run=1 until reset.
REQ-037 Reset asserted during WAIT and during HOLD -> all outputs at REQ-028 values next cycle and no pc_en pulse; run deasserted in WAIT -> word still delivered, then IDLE.
